tag_resolver: RTL
=================

# tag_resolver

Parametrised tag register and response resolver for the associative processor array. Combines NUM_KEY per-row match vectors into a registered tag vector, supports multi-pass accumulation (AND/OR), maintains the TSC tag, and reports a population count. A handshake-driven scan engine walks tagged rows lowest-index first so the controller can service each responder in turn.

## Interface
- DATA_DEPTH, 128, number of rows (tag bits)
- NUM_KEY, 3, number of match-vector inputs
- IDX_W, 7, row index width; must satisfy 2^IDX_W >= DATA_DEPTH
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- match_in  in  NUM_KEY*DATA_DEPTH  key k occupies bits [k*DATA_DEPTH +: DATA_DEPTH]
- key_mask  in  NUM_KEY  1 = key participates in the combine
- tsc_in  in  DATA_DEPTH  TSC flag vector
- op  in  3  0 NOP, 1 LOAD, 2 AND_ACC, 3 OR_ACC, 4 SET_ALL, 5 CLEAR, 6–7 NOP
- op_valid  in  1  op qualifier
- tag  out  DATA_DEPTH  registered tag vector
- tag_tsc  out  DATA_DEPTH  registered TSC tag vector
- any_tag  out  1  |tag
- tag_count  out  IDX_W+1  popcount(tag)
- scan_start  in  1  request a scan of the current tag
- idx_valid  out  1  idx_out holds a tagged row
- idx_ready  in  1  consumer accepts idx_out
- idx_out  out  IDX_W  row index
- scan_done  out  1  one-cycle pulse, scan finished
- busy  out  1  scan engine not IDLE

## Operation
- comb[i] = AND over k with key_mask[k]=1 of match_in[k][i]; key_mask=0 gives comb = all ones.
- On op_valid at rising edge:
  - LOAD: tag <= comb; tag_tsc <= comb & tsc_in.
  - AND_ACC: tag <= tag & comb; tag_tsc <= tag_tsc & comb & tsc_in.
  - OR_ACC: tag <= tag | comb; tag_tsc <= tag_tsc | (comb & tsc_in).
  - SET_ALL: tag <= all ones; tag_tsc unchanged.
  - CLEAR: tag <= 0; tag_tsc <= 0.
  - NOP / op_valid=0: hold both vectors.
- any_tag and tag_count: combinational from the tag register.
- Scan FSM states: IDLE, SCAN, DONE.
  - IDLE: if scan_start, scan_vec <= tag. Go to SCAN if tag != 0, else DONE.
  - SCAN: idx_valid=1, idx_out = lowest set bit of scan_vec. On idx_valid & idx_ready, clear that bit. Go to DONE if the cleared vector is zero, else stay in SCAN.
  - DONE: scan_done=1 for one cycle, then IDLE.
- scan_start outside IDLE is ignored.
- tag ops during SCAN/DONE update tag/tag_tsc normally; scan_vec (the snapshot) is unaffected.
- busy = (state != IDLE). idx_out is 0 when idx_valid=0.

## Timing
- Reset values: tag=0, tag_tsc=0, any_tag=0, tag_count=0, idx_valid=0, idx_out=0, scan_done=0, busy=0. State IDLE, scan_vec=0.
- Reset asserted mid-scan aborts immediately: no scan_done pulse; all outputs return to reset values.
- Op latency: op_valid at edge t changes tag visible after t; any_tag/tag_count follow in the same cycle as tag.
- Scan timing:
  - scan_start sampled at edge t gives idx_valid=1 after t.
  - Each accepted index advances one row per cycle; idx_ready held high gives one index per cycle.
  - Last handshake at edge k gives scan_done=1 in cycle k..k+1, busy low after k+1.
  - Empty tag: scan_start at t gives scan_done in the cycle after t, with no idx_valid.
- idx_valid, once high, stays high with idx_out stable until accepted; idx_ready may be asserted at any time.
- tag_count range is 0..DATA_DEPTH inclusive, hence IDX_W+1 bits.

## Test plan
All scenarios use DATA_DEPTH=8, NUM_KEY=3.
- Reset release: all outputs 0. LOAD with match keys 0xFF/0xF0/0x3C, mask=3'b111, tsc_in=0x20 -> tag=0x30, tag_tsc=0x20, tag_count=2, any_tag=1.
- Accumulate: LOAD comb=0x0F, then AND_ACC comb=0x3C -> tag=0x0C. OR_ACC comb=0x81 -> tag=0x8D, tag_count=4. key_mask=0 with LOAD -> tag=0xFF.
- Scan with idx_ready tied high, tag=0x8D -> idx_out 0,2,3,7 on consecutive cycles. scan_done pulses once; busy drops the next cycle.
- Backpressure, tag=0x12, idx_ready low 3 cycles -> idx_out=1 held stable with idx_valid=1. After acceptance, idx_out=4.
- Op during scan: scan on tag=0x12; CLEAR issued while idx_out=1 -> tag=0 but scan still yields 4, then scan_done. A second scan_start issued mid-scan is ignored.
- Empty tag and reset: scan_start with tag=0 -> scan_done next cycle, no idx_valid. Reset asserted mid-scan -> idx_valid, busy, tag clear asynchronously, no scan_done.

Source files
------------

// File: rtl/tag_resolver.sv
// Tag register and response resolver: combines per-key match vectors into tag/TSC tag,
// reports popcount, and walks tagged rows lowest-index first over a valid/ready port.
module tag_resolver #(
  parameter int DATA_DEPTH = 128,
  parameter int NUM_KEY    = 3,
  parameter int IDX_W      = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_KEY*DATA_DEPTH-1:0] match_in,
  input  logic [NUM_KEY-1:0]            key_mask,
  input  logic [DATA_DEPTH-1:0]         tsc_in,
  input  logic [2:0]                    op,
  input  logic                          op_valid,
  output logic [DATA_DEPTH-1:0]         tag,
  output logic [DATA_DEPTH-1:0]         tag_tsc,
  output logic                          any_tag,
  output logic [IDX_W:0]                tag_count,
  input  logic                          scan_start,
  output logic                          idx_valid,
  input  logic                          idx_ready,
  output logic [IDX_W-1:0]              idx_out,
  output logic                          scan_done,
  output logic                          busy,
  output logic [1:0]                    scan_state
);

  localparam logic [2:0] OP_LOAD    = 3'd1;
  localparam logic [2:0] OP_AND_ACC = 3'd2;
  localparam logic [2:0] OP_OR_ACC  = 3'd3;
  localparam logic [2:0] OP_SET_ALL = 3'd4;
  localparam logic [2:0] OP_CLEAR   = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } scan_state_e;

  scan_state_e             state;
  logic [DATA_DEPTH-1:0]   comb;
  logic [DATA_DEPTH-1:0]   scan_vec;
  logic [DATA_DEPTH-1:0]   scan_vec_next;
  logic [IDX_W-1:0]        lowest_idx;
  logic                    handshake;

  // A key with mask 0 drops out of the AND; no participating keys yields all ones.
  always_comb begin
    comb = '1;
    for (int k = 0; k < NUM_KEY; k++) begin
      if (key_mask[k]) comb = comb & match_in[k*DATA_DEPTH +: DATA_DEPTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag     <= '0;
      tag_tsc <= '0;
    end else if (op_valid) begin
      case (op)
        OP_LOAD: begin
          tag     <= comb;
          tag_tsc <= comb & tsc_in;
        end
        OP_AND_ACC: begin
          tag     <= tag & comb;
          tag_tsc <= tag_tsc & comb & tsc_in;
        end
        OP_OR_ACC: begin
          tag     <= tag | comb;
          tag_tsc <= tag_tsc | (comb & tsc_in);
        end
        OP_SET_ALL: tag <= '1;
        OP_CLEAR: begin
          tag     <= '0;
          tag_tsc <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tag_count = '0;
    for (int i = 0; i < DATA_DEPTH; i++) begin
      tag_count = tag_count + (IDX_W+1)'(tag[i]);
    end
  end

  assign any_tag = |tag;

  // Descending loop so the lowest set bit is the last (winning) assignment.
  always_comb begin
    lowest_idx = '0;
    for (int i = DATA_DEPTH-1; i >= 0; i--) begin
      if (scan_vec[i]) lowest_idx = IDX_W'(i);
    end
  end

  // Handshake: idx_out transfers on a rising edge where idx_valid and idx_ready are
  // both high; idx_valid never drops and idx_out never changes before that transfer.
  assign handshake     = (state == S_SCAN) && idx_ready;
  assign scan_vec_next = scan_vec & (scan_vec - 1'b1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      scan_vec <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (scan_start) begin
            scan_vec <= tag;
            state    <= (tag != '0) ? S_SCAN : S_DONE;
          end
        end
        S_SCAN: begin
          if (handshake) begin
            scan_vec <= scan_vec_next;
            if (scan_vec_next == '0) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign idx_valid  = (state == S_SCAN);
  assign idx_out    = idx_valid ? lowest_idx : '0;
  assign scan_done  = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign scan_state = state;

endmodule
